// File: rtl/sine_seq_pkg.sv
// rtl/sine_seq_pkg.sv - shared widths, FSM states and phase-to-ROM-select helper for the sine voice sequencer
package sine_seq_pkg;

  localparam int ROM_AW = 9;
  localparam int ROM_DW = 16;
  localparam int FRAC_W = 8;
  localparam logic [ROM_DW-1:0] SMP_MAX = 16'd32767;
  // Phase bits that matter for lookup: quadrant, ROM address, interpolation fraction
  localparam int TOP_W = 2 + ROM_AW + FRAC_W;

  typedef enum logic [1:0] {IDLE, FETCH, MUL, OUT} seq_state_e;

  typedef struct packed {
    logic              neg;
    logic [ROM_AW-1:0] a;
    logic [FRAC_W-1:0] f;
  } rom_sel_t;

  // Odd quadrants walk the quarter wave backwards, upper half-cycle is negated.
  function automatic rom_sel_t phase_to_sel(input logic [TOP_W-1:0] top);
    rom_sel_t s;
    s.neg = top[TOP_W-1];
    s.a   = top[TOP_W-3 -: ROM_AW] ^ {ROM_AW{top[TOP_W-2]}};
    s.f   = top[FRAC_W-1:0] ^ {FRAC_W{top[TOP_W-2]}};
    return s;
  endfunction

endpackage

// File: rtl/sine_interp.sv
// rtl/sine_interp.sv - latches ROM pair, then interpolates, caps and signs one sample
module sine_interp
  import sine_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              calc_i,
  input  logic [ROM_DW-1:0] base_i,
  input  logic [ROM_DW-1:0] diff_i,
  input  logic [FRAC_W-1:0] frac_i,
  input  logic              neg_i,
  output logic [ROM_DW-1:0] smp_o
);

  localparam int PW = ROM_DW + FRAC_W;

  logic [ROM_DW-1:0] base_q, diff_q, smp_q, smp_d, mag;
  logic [FRAC_W-1:0] frac_q;
  logic              neg_q;
  logic [PW-1:0]     prod, sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      diff_q <= '0;
      frac_q <= '0;
      neg_q  <= 1'b0;
      smp_q  <= '0;
    end else begin
      if (load_i) begin
        base_q <= base_i;
        diff_q <= diff_i;
        frac_q <= frac_i;
        neg_q  <= neg_i;
      end
      if (calc_i) smp_q <= smp_d;
    end
  end

  // Sum kept full width so the cap compare sees any carry past 32767
  always_comb begin
    prod  = diff_q * frac_q;
    sum   = PW'(base_q) + (prod >> FRAC_W);
    mag   = (sum > PW'(SMP_MAX)) ? SMP_MAX : sum[ROM_DW-1:0];
    smp_d = neg_q ? (16'd0 - mag) : mag;
  end

  assign smp_o = smp_q;

endmodule

// File: rtl/sine_voice_sequencer.sv
// rtl/sine_voice_sequencer.sv - walks all voices once per sample_tick through one shared sine ROM pair
module sine_voice_sequencer
  import sine_seq_pkg::*;
#(
  parameter int NVOICE  = 8,
  parameter int VID_W   = 3,
  parameter int PHASE_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic               cfg_we,
  input  logic [VID_W-1:0]   cfg_voice,
  input  logic [PHASE_W-1:0] cfg_inc,
  input  logic               cfg_phase_clr,
  input  logic               ovr_clr,
  output logic [ROM_AW-1:0]  rom_adrs,
  input  logic [ROM_DW-1:0]  rom_base,
  input  logic [ROM_DW-1:0]  rom_diff,
  output logic               smp_valid,
  output logic [VID_W-1:0]   smp_voice,
  output logic [ROM_DW-1:0]  smp_data,
  output logic               busy,
  output logic               overrun
);

  seq_state_e         state_q, state_d;
  logic [VID_W-1:0]   vid_q, vid_d;
  rom_sel_t           sel_q, sel_d;
  logic               ovr_q, ovr_d;
  logic [PHASE_W-1:0] ph_q  [NVOICE];
  logic [PHASE_W-1:0] inc_q [NVOICE];
  logic               last_voice, fetch_start, load_en, calc_en;

  assign last_voice = (vid_q == VID_W'(NVOICE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vid_q   <= '0;
      sel_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vid_q   <= vid_d;
      sel_q   <= sel_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vid_d   = vid_q;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = FETCH;
          vid_d   = '0;
        end
      end
      FETCH: state_d = MUL;
      MUL:   state_d = OUT;
      OUT: begin
        if (last_voice) begin
          state_d = IDLE;
        end else begin
          state_d = FETCH;
          vid_d   = vid_q + VID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_start = 1'b0;
    load_en     = 1'b0;
    calc_en     = 1'b0;
    smp_valid   = 1'b0;
    busy        = 1'b1;
    case (state_q)
      IDLE: begin
        busy        = 1'b0;
        fetch_start = sample_tick;
      end
      FETCH: load_en = 1'b1;
      MUL:   calc_en = 1'b1;
      OUT: begin
        smp_valid   = 1'b1;
        fetch_start = !last_voice;
      end
      default: busy = 1'b0;
    endcase
    // Address is registered one cycle ahead so ROM data is ready during FETCH
    sel_d = fetch_start ? phase_to_sel(ph_q[vid_d][PHASE_W-1 -: TOP_W]) : sel_q;
    ovr_d = (sample_tick && state_q != IDLE) ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
  end

  // Later assignment wins: a phase clear overrides the same voice's advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NVOICE; v++) begin
        ph_q[v]  <= '0;
        inc_q[v] <= '0;
      end
    end else begin
      if (smp_valid) ph_q[vid_q] <= ph_q[vid_q] + inc_q[vid_q];
      if (cfg_phase_clr) ph_q[cfg_voice] <= '0;
      if (cfg_we) inc_q[cfg_voice] <= cfg_inc;
    end
  end

  sine_interp u_interp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load_en),
    .calc_i (calc_en),
    .base_i (rom_base),
    .diff_i (rom_diff),
    .frac_i (sel_q.f),
    .neg_i  (sel_q.neg),
    .smp_o  (smp_data)
  );

  assign rom_adrs  = sel_q.a;
  assign smp_voice = vid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sine_voice_sequencer.sv
// tb/tb_sine_voice_sequencer.sv - self-checking bench for sine_voice_sequencer
module tb_sine_voice_sequencer;

  localparam int NV = 8;
  localparam int VW = 3;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b0;
  logic          cfg_we = 1'b0;
  logic [VW-1:0] cfg_voice = '0;
  logic [PW-1:0] cfg_inc = '0;
  logic          cfg_phase_clr = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [8:0]    rom_adrs;
  logic [15:0]   rom_base, rom_diff;
  logic          smp_valid;
  logic [VW-1:0] smp_voice;
  logic [15:0]   smp_data;
  logic          busy, overrun;

  always #5 clk = ~clk;

  assign rom_base = {1'b0, rom_adrs, 6'b0};
  assign rom_diff = 16'd64;

  sine_voice_sequencer #(.NVOICE(NV), .VID_W(VW), .PHASE_W(PW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_tick   (sample_tick),
    .cfg_we        (cfg_we),
    .cfg_voice     (cfg_voice),
    .cfg_inc       (cfg_inc),
    .cfg_phase_clr (cfg_phase_clr),
    .ovr_clr       (ovr_clr),
    .rom_adrs      (rom_adrs),
    .rom_base      (rom_base),
    .rom_diff      (rom_diff),
    .smp_valid     (smp_valid),
    .smp_voice     (smp_voice),
    .smp_data      (smp_data),
    .busy          (busy),
    .overrun       (overrun)
  );

  typedef struct {
    logic [VW-1:0] voice;
    logic [15:0]   data;
  } exp_t;

  typedef struct {
    int          voice;
    logic [23:0] ph;
    logic [15:0] data;
  } vec_t;

  int            errors = 0;
  int            checks = 0;
  int            strobes = 0;
  exp_t          sb[$];
  logic [PW-1:0] m_ph  [NV];
  logic [PW-1:0] m_inc [NV];
  vec_t          tbl   [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stub ROM is base=adrs*64, diff=64, so interpolation adds f'/4
  function automatic logic [15:0] model(input logic [PW-1:0] ph);
    int a, f, q, m;
    logic [31:0] r;
    q = int'(ph[23:22]);
    a = int'(ph[21:13]);
    f = int'(ph[12:5]);
    if (q == 1 || q == 3) begin
      a = 511 - a;
      f = 255 - f;
    end
    m = a * 64 + (f * 64) / 256;
    if (m > 32767) m = 32767;
    if (q >= 2) m = -m;
    r = m;
    return r[15:0];
  endfunction

  task automatic push_frame(input int ov_voice, input logic [15:0] ov_exp);
    for (int v = 0; v < NV; v++) begin
      exp_t e;
      e.voice = VW'(v);
      e.data  = (v == ov_voice) ? ov_exp : model(m_ph[v]);
      sb.push_back(e);
      m_ph[v] = m_ph[v] + m_inc[v];
    end
  endtask

  task automatic cfg(input int v, input logic we, input logic [PW-1:0] inc, input logic clr);
    @(negedge clk);
    cfg_voice     = VW'(v);
    cfg_we        = we;
    cfg_inc       = inc;
    cfg_phase_clr = clr;
    if (clr) m_ph[v] = '0;
    if (we) m_inc[v] = inc;
    @(negedge clk);
    cfg_we        = 1'b0;
    cfg_phase_clr = 1'b0;
  endtask

  task automatic run_frame(input int ov_voice, input logic [15:0] ov_exp,
                           input int extra_at, input logic extra_clr);
    int cyc, busy_cnt, s0;
    @(negedge clk);
    sample_tick = 1'b1;
    push_frame(ov_voice, ov_exp);
    s0 = strobes;
    @(negedge clk);
    sample_tick = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    while (busy && cyc < 60) begin
      busy_cnt++;
      if (cyc == extra_at) begin
        sample_tick = 1'b1;
        ovr_clr     = extra_clr;
      end
      @(negedge clk);
      sample_tick = 1'b0;
      ovr_clr     = 1'b0;
      cyc++;
    end
    check("busy_cycles", busy_cnt, 24);
    check("strobe_count", strobes - s0, 8);
    check("sb_drained", sb.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && smp_valid) begin
      strobes++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got voice %0d data %0h expected no strobe", smp_voice, smp_data);
      end else begin
        e = sb.pop_front();
        check("smp_voice", smp_voice, e.voice);
        check("smp_data", smp_data, e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int v = 0; v < NV; v++) begin
      m_ph[v]  = '0;
      m_inc[v] = '0;
    end
    tbl[0] = '{1, 24'h014000, 16'd640};
    tbl[1] = '{1, 24'h014100, 16'd642};
    tbl[2] = '{2, 24'h400000, 16'd32767};
    tbl[3] = '{3, 24'h815000, 16'hFD60};
    tbl[4] = '{4, 24'hC00000, 16'h8001};
    tbl[5] = '{5, 24'h3FFFE0, 16'd32767};
    tbl[6] = '{6, 24'h000000, 16'd0};

    repeat (3) @(negedge clk);
    check("rst_rom_adrs", rom_adrs, 0);
    check("rst_smp_valid", smp_valid, 0);
    check("rst_smp_voice", smp_voice, 0);
    check("rst_smp_data", smp_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    run_frame(-1, 16'd0, -1, 1'b0);

    cfg(0, 1'b1, 24'h002000, 1'b1);
    repeat (4) run_frame(-1, 16'd0, -1, 1'b0);

    foreach (tbl[i]) begin
      cfg(tbl[i].voice, 1'b1, tbl[i].ph, 1'b1);
      run_frame(-1, 16'd0, -1, 1'b0);
      cfg(tbl[i].voice, 1'b1, 24'h0, 1'b0);
      run_frame(tbl[i].voice, tbl[i].data, -1, 1'b0);
    end

    check("ovr_idle", overrun, 0);
    run_frame(-1, 16'd0, 5, 1'b0);
    check("ovr_set_busy", overrun, 1);
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_cleared", overrun, 0);
    run_frame(-1, 16'd0, 7, 1'b1);
    check("ovr_set_beats_clr", overrun, 1);
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    run_frame(-1, 16'd0, 24, 1'b0);
    check("ovr_last_out", overrun, 1);

    // Abort mid-frame at cycle 10 (FETCH of voice 3)
    @(negedge clk);
    sample_tick = 1'b1;
    push_frame(-1, 16'd0);
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_smp_valid", smp_valid, 0);
    check("arst_rom_adrs", rom_adrs, 0);
    check("arst_smp_data", smp_data, 0);
    check("arst_smp_voice", smp_voice, 0);
    check("arst_overrun", overrun, 0);
    sb.delete();
    for (int v = 0; v < NV; v++) begin
      m_ph[v]  = '0;
      m_inc[v] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(-1, 16'd0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
